// File: rtl/mem_stage.sv
// MIPS memory-access stage: EX/MEM register, big-endian data memory with sub-word access,
// branch resolution back to fetch, and the MEM/WB register carrying the final write-back value.
module mem_stage #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall_In,
    input  logic        Flush_In,
    input  logic [31:0] ALUResult_In,
    input  logic [31:0] StoreData_In,
    input  logic [31:0] BranchTarget_In,
    input  logic [31:0] ReadDataHi_In,
    input  logic [31:0] ReadDataLo_In,
    input  logic        Zero_In,
    input  logic [4:0]  WriteRegister_In,
    input  logic        RegWrite_In,
    input  logic        MemToReg_In,
    input  logic        MemRead_In,
    input  logic        MemWrite_In,
    input  logic        Branch_In,
    input  logic        HiLoToReg_In,
    input  logic        HiOrLo_In,
    input  logic        MoveNotZero_In,
    input  logic        DontMove_In,
    input  logic [1:0]  Size_In,
    input  logic        SignedLoad_In,
    output logic        Branch_Out,
    output logic [31:0] BranchAddress_Out,
    output logic        RegWrite_WB,
    output logic [4:0]  WriteRegister_WB,
    output logic [31:0] WriteData_WB,
    output logic        MisalignFault_WB
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       hilo_to_reg;
        logic       hi_or_lo;
        logic       move_not_zero;
        logic       dont_move;
        logic [1:0] size;
        logic       signed_load;
    } ctrl_t;

    ctrl_t       w_ctrl_in;
    ctrl_t       r_ctrl;
    logic [31:0] r_alu, r_store, r_target, r_hi, r_lo;
    logic        r_zero;
    logic [4:0]  r_wreg;

    assign w_ctrl_in = '{reg_write: RegWrite_In, mem_to_reg: MemToReg_In,
                         mem_read: MemRead_In, mem_write: MemWrite_In, branch: Branch_In,
                         hilo_to_reg: HiLoToReg_In, hi_or_lo: HiOrLo_In,
                         move_not_zero: MoveNotZero_In, dont_move: DontMove_In,
                         size: Size_In, signed_load: SignedLoad_In};

    // EX/MEM register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ctrl   <= '0;
            r_alu    <= '0;
            r_store  <= '0;
            r_target <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_zero   <= 1'b0;
            r_wreg   <= '0;
        end else if (!Stall_In) begin
            r_ctrl   <= Flush_In ? '0 : w_ctrl_in;
            r_alu    <= ALUResult_In;
            r_store  <= StoreData_In;
            r_target <= BranchTarget_In;
            r_hi     <= ReadDataHi_In;
            r_lo     <= ReadDataLo_In;
            r_zero   <= Zero_In;
            r_wreg   <= WriteRegister_In;
        end
    end

    assign Branch_Out        = r_ctrl.branch & r_zero;
    assign BranchAddress_Out = r_target;

    logic          w_fault, w_we, w_move_ok, w_regwrite, w_wb_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata, w_wb_data;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    assign w_idx    = r_alu[AW+1:2];
    assign w_unused = ^r_alu[31:AW+2];

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_store;
        w_fault = 1'b0;
        case (r_ctrl.size)
            2'b01: begin
                w_be    = r_alu[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{r_store[15:0]}};
                w_fault = r_alu[0];
            end
            2'b10: begin
                // be[3] is bits 31:24, i.e. byte offset 0 (big-endian)
                w_be    = 4'b1000 >> r_alu[1:0];
                w_wdata = {4{r_store[7:0]}};
            end
            default: w_fault = |r_alu[1:0];
        endcase
        w_fault = w_fault & (r_ctrl.mem_read | r_ctrl.mem_write);
    end

    assign w_we       = r_ctrl.mem_write & ~w_fault & ~Stall_In & ~Rst;
    assign w_move_ok  = r_ctrl.dont_move | (r_ctrl.move_not_zero ? ~r_zero : r_zero);
    assign w_regwrite = r_ctrl.reg_write & ~w_fault & w_move_ok;
    assign w_wb_load  = r_ctrl.mem_to_reg & ~r_ctrl.hilo_to_reg & ~w_fault;
    // Non-load write-back value; a faulting load yields 0 here since w_wb_load is cleared.
    assign w_wb_data  = r_ctrl.hilo_to_reg ? (r_ctrl.hi_or_lo ? r_hi : r_lo)
                      : r_ctrl.mem_to_reg  ? 32'h0 : r_alu;

    logic [31:0] r_mem [MEM_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge Clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
            end
        end
        if (!Stall_In) r_rdata <= r_mem[w_idx];
    end

    logic        r_wb_regwrite, r_wb_load, r_wb_fault, r_wb_signed;
    logic [4:0]  r_wb_reg;
    logic [31:0] r_wb_data;
    logic [1:0]  r_wb_lane, r_wb_size;

    // MEM/WB register; the loaded word is registered raw and its lane extracted afterwards
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wb_regwrite <= 1'b0;
            r_wb_load     <= 1'b0;
            r_wb_fault    <= 1'b0;
            r_wb_signed   <= 1'b0;
            r_wb_reg      <= '0;
            r_wb_data     <= '0;
            r_wb_lane     <= '0;
            r_wb_size     <= '0;
        end else if (!Stall_In) begin
            r_wb_regwrite <= w_regwrite;
            r_wb_load     <= w_wb_load;
            r_wb_fault    <= w_fault;
            r_wb_signed   <= r_ctrl.signed_load;
            r_wb_reg      <= r_wreg;
            r_wb_data     <= w_wb_data;
            r_wb_lane     <= r_alu[1:0];
            r_wb_size     <= r_ctrl.size;
        end
    end

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    always_comb begin
        w_byte = r_rdata[31:24];
        case (r_wb_lane)
            2'd1:    w_byte = r_rdata[23:16];
            2'd2:    w_byte = r_rdata[15:8];
            2'd3:    w_byte = r_rdata[7:0];
            default: w_byte = r_rdata[31:24];
        endcase
        w_half = r_wb_lane[1] ? r_rdata[15:0] : r_rdata[31:16];
        case (r_wb_size)
            2'b01:   w_load_data = {{16{r_wb_signed & w_half[15]}}, w_half};
            2'b10:   w_load_data = {{24{r_wb_signed & w_byte[7]}}, w_byte};
            default: w_load_data = r_rdata;
        endcase
    end

    assign RegWrite_WB      = r_wb_regwrite;
    assign WriteRegister_WB = r_wb_reg;
    assign WriteData_WB     = r_wb_load ? w_load_data : r_wb_data;
    assign MisalignFault_WB = r_wb_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, loads/stores, misalignment, branches,
// conditional moves and stalls.
module tb_mem_stage;

    logic        Clk = 1'b0;
    logic        Rst, Stall_In, Flush_In;
    logic [31:0] ALUResult_In, StoreData_In, BranchTarget_In, ReadDataHi_In, ReadDataLo_In;
    logic        Zero_In;
    logic [4:0]  WriteRegister_In;
    logic        RegWrite_In, MemToReg_In, MemRead_In, MemWrite_In, Branch_In;
    logic        HiLoToReg_In, HiOrLo_In, MoveNotZero_In, DontMove_In;
    logic [1:0]  Size_In;
    logic        SignedLoad_In;
    logic        Branch_Out, RegWrite_WB, MisalignFault_WB;
    logic [31:0] BranchAddress_Out, WriteData_WB;
    logic [4:0]  WriteRegister_WB;

    int total = 0;
    int bad   = 0;

    mem_stage #(.MEM_WORDS(1024)) dut (
        .Clk(Clk), .Rst(Rst), .Stall_In(Stall_In), .Flush_In(Flush_In),
        .ALUResult_In(ALUResult_In), .StoreData_In(StoreData_In),
        .BranchTarget_In(BranchTarget_In), .ReadDataHi_In(ReadDataHi_In),
        .ReadDataLo_In(ReadDataLo_In), .Zero_In(Zero_In), .WriteRegister_In(WriteRegister_In),
        .RegWrite_In(RegWrite_In), .MemToReg_In(MemToReg_In), .MemRead_In(MemRead_In),
        .MemWrite_In(MemWrite_In), .Branch_In(Branch_In), .HiLoToReg_In(HiLoToReg_In),
        .HiOrLo_In(HiOrLo_In), .MoveNotZero_In(MoveNotZero_In), .DontMove_In(DontMove_In),
        .Size_In(Size_In), .SignedLoad_In(SignedLoad_In), .Branch_Out(Branch_Out),
        .BranchAddress_Out(BranchAddress_Out), .RegWrite_WB(RegWrite_WB),
        .WriteRegister_WB(WriteRegister_WB), .WriteData_WB(WriteData_WB),
        .MisalignFault_WB(MisalignFault_WB)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        ALUResult_In = 0; StoreData_In = 0; BranchTarget_In = 0;
        ReadDataHi_In = 0; ReadDataLo_In = 0; Zero_In = 0; WriteRegister_In = 0;
        RegWrite_In = 0; MemToReg_In = 0; MemRead_In = 0; MemWrite_In = 0; Branch_In = 0;
        HiLoToReg_In = 0; HiOrLo_In = 0; MoveNotZero_In = 0; DontMove_In = 0;
        Size_In = 0; SignedLoad_In = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op_sw(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        clr();
        ALUResult_In = a; StoreData_In = d; MemWrite_In = 1; Size_In = sz;
        tick();
        clr();
    endtask

    task automatic op_ld(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        clr();
        ALUResult_In = a; Size_In = sz; SignedLoad_In = sg; MemRead_In = 1; MemToReg_In = 1;
        RegWrite_In = 1; DontMove_In = 1; WriteRegister_In = 5'd9;
        tick();
        clr();
    endtask

    task automatic ld_chk(input string tag, input logic [31:0] a, input logic [1:0] sz,
                          input logic sg, input logic [31:0] exp);
        op_ld(a, sz, sg);
        tick();
        chk(tag, WriteData_WB, exp);
    endtask

    initial begin
        Rst = 1; Stall_In = 0; Flush_In = 0;
        clr();
        tick();
        tick();
        Rst = 0;

        // Reset with a store in flight and non-zero state downstream
        op_sw(32'h20, 32'h1111_1111, 2'b00);
        tick();
        RegWrite_In = 1; DontMove_In = 1; ALUResult_In = 32'h1234; WriteRegister_In = 5'd3;
        tick();
        clr();
        ALUResult_In = 32'h20; StoreData_In = 32'h2222_2222; MemWrite_In = 1;
        BranchTarget_In = 32'h80;
        tick();
        clr();
        Rst = 1;
        tick();
        tick();
        Rst = 0;
        chk("rst_branch", {31'b0, Branch_Out}, 32'h0);
        chk("rst_baddr", BranchAddress_Out, 32'h0);
        chk("rst_regwrite", {31'b0, RegWrite_WB}, 32'h0);
        chk("rst_wreg", {27'b0, WriteRegister_WB}, 32'h0);
        chk("rst_wdata", WriteData_WB, 32'h0);
        chk("rst_fault", {31'b0, MisalignFault_WB}, 32'h0);
        ld_chk("rst_mem_kept", 32'h20, 2'b00, 1'b0, 32'h1111_1111);

        // Store immediately followed by a load of the same word
        op_sw(32'h10, 32'hDEAD_BEEF, 2'b00);
        ld_chk("sw_lw_data", 32'h10, 2'b00, 1'b0, 32'hDEAD_BEEF);
        chk("sw_lw_regwrite", {31'b0, RegWrite_WB}, 32'h1);
        chk("sw_lw_wreg", {27'b0, WriteRegister_WB}, 32'd9);

        // Sub-word stores and loads
        op_sw(32'h11, 32'h1234_567F, 2'b10);
        ld_chk("sb_lw", 32'h10, 2'b00, 1'b0, 32'hDE7F_BEEF);
        ld_chk("lb", 32'h10, 2'b10, 1'b1, 32'hFFFF_FFDE);
        ld_chk("lbu", 32'h10, 2'b10, 1'b0, 32'h0000_00DE);
        ld_chk("lh", 32'h12, 2'b01, 1'b1, 32'hFFFF_BEEF);
        ld_chk("lhu", 32'h10, 2'b01, 1'b0, 32'h0000_DE7F);
        ld_chk("lbu3", 32'h13, 2'b10, 1'b0, 32'h0000_00EF);
        op_sw(32'h12, 32'hABCD_1234, 2'b01);
        ld_chk("sh_lw", 32'h10, 2'b00, 1'b0, 32'hDE7F_1234);
        ld_chk("size11_word", 32'h10, 2'b11, 1'b1, 32'hDE7F_1234);

        // Misaligned accesses
        op_ld(32'h6, 2'b00, 1'b0);
        tick();
        chk("mis_lw_fault", {31'b0, MisalignFault_WB}, 32'h1);
        chk("mis_lw_regwrite", {31'b0, RegWrite_WB}, 32'h0);
        chk("mis_lw_data", WriteData_WB, 32'h0);
        op_sw(32'h0, 32'h0102_0304, 2'b00);
        op_sw(32'h2, 32'hCAFE_F00D, 2'b00);
        tick();
        chk("mis_sw_fault", {31'b0, MisalignFault_WB}, 32'h1);
        op_sw(32'h11, 32'h0000_FFFF, 2'b01);
        ld_chk("mis_sw_kept", 32'h0, 2'b00, 1'b0, 32'h0102_0304);
        ld_chk("mis_sh_kept", 32'h10, 2'b00, 1'b0, 32'hDE7F_1234);
        ld_chk("lh_mis_data", 32'h11, 2'b01, 1'b1, 32'h0);

        // Address wrap modulo depth
        op_sw(32'h1040, 32'h5A5A_0F0F, 2'b00);
        ld_chk("wrap", 32'h40, 2'b00, 1'b0, 32'h5A5A_0F0F);

        // Branch resolution
        clr();
        Branch_In = 1; Zero_In = 1; BranchTarget_In = 32'h40;
        tick();
        chk("br_taken", {31'b0, Branch_Out}, 32'h1);
        chk("br_addr", BranchAddress_Out, 32'h40);
        clr();
        tick();
        chk("br_one_cycle", {31'b0, Branch_Out}, 32'h0);
        Branch_In = 1; Zero_In = 1; BranchTarget_In = 32'h40; Flush_In = 1;
        tick();
        Flush_In = 0;
        chk("br_flushed", {31'b0, Branch_Out}, 32'h0);
        Branch_In = 1; Zero_In = 0;
        tick();
        chk("br_not_zero", {31'b0, Branch_Out}, 32'h0);

        // Flush together with stall: stall wins
        Branch_In = 1; Zero_In = 1; BranchTarget_In = 32'h44;
        tick();
        clr();
        Stall_In = 1; Flush_In = 1;
        tick();
        chk("stallflush_br", {31'b0, Branch_Out}, 32'h1);
        tick();
        chk("stallflush_addr", BranchAddress_Out, 32'h44);
        Stall_In = 0;
        tick();
        Flush_In = 0;
        chk("flush_after", {31'b0, Branch_Out}, 32'h0);

        // Conditional moves
        clr();
        RegWrite_In = 1; MoveNotZero_In = 1; Zero_In = 1; ALUResult_In = 32'h99;
        WriteRegister_In = 5'd4;
        tick(); clr(); tick();
        chk("movn_z1", {31'b0, RegWrite_WB}, 32'h0);
        RegWrite_In = 1; MoveNotZero_In = 1; Zero_In = 0; ALUResult_In = 32'h99;
        tick(); clr(); tick();
        chk("movn_z0_we", {31'b0, RegWrite_WB}, 32'h1);
        chk("movn_z0_data", WriteData_WB, 32'h99);
        RegWrite_In = 1; Zero_In = 1; HiLoToReg_In = 1; HiOrLo_In = 1;
        ReadDataHi_In = 32'h5; ReadDataLo_In = 32'h7;
        tick(); clr(); tick();
        chk("movz_z1_we", {31'b0, RegWrite_WB}, 32'h1);
        chk("movz_hi_data", WriteData_WB, 32'h5);
        RegWrite_In = 1; Zero_In = 0; HiLoToReg_In = 1; HiOrLo_In = 1;
        tick(); clr(); tick();
        chk("movz_z0_we", {31'b0, RegWrite_WB}, 32'h0);
        RegWrite_In = 1; DontMove_In = 1; HiLoToReg_In = 1; MemToReg_In = 1;
        ReadDataHi_In = 32'h5; ReadDataLo_In = 32'h7; ALUResult_In = 32'h33;
        tick(); clr(); tick();
        chk("mflo_data", WriteData_WB, 32'h7);

        // Store held by a 3-cycle stall; WB must stay frozen
        RegWrite_In = 1; DontMove_In = 1; ALUResult_In = 32'hAAAA_0000; WriteRegister_In = 5'd7;
        tick();
        op_sw(32'h30, 32'h1234_5678, 2'b00);
        Stall_In = 1;
        ALUResult_In = 32'h10; MemRead_In = 1; MemToReg_In = 1; RegWrite_In = 1;
        DontMove_In = 1; WriteRegister_In = 5'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_wdata", WriteData_WB, 32'hAAAA_0000);
            chk("stall_we", {31'b0, RegWrite_WB}, 32'h1);
            chk("stall_wreg", {27'b0, WriteRegister_WB}, 32'd7);
        end
        Stall_In = 0;
        clr();
        tick();
        chk("stall_release_we", {31'b0, RegWrite_WB}, 32'h0);
        ld_chk("stall_sw_data", 32'h30, 2'b00, 1'b0, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
